// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: stages receiver bytes, closes frames on idle
// timeout, BREAK or disable, and queues {last,data} in a FWFT FIFO.
module uart_rx_frame_ctrl #(
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int IDLE_BITS    = 20,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          rx_valid,
  input  logic                          rx_break,
  input  logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          uart_rx_en,
  output logic [PAYLOAD_BITS-1:0]       m_data,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic                          break_det
);
  localparam int TIMEOUT_CYCLES = (CLK_HZ / BIT_RATE) * IDLE_BITS;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {OFF, ARMED, FRAME} state_t;

  state_t                  state;
  logic [PAYLOAD_BITS-1:0] stage;
  logic [TW-1:0]           timer;
  logic                    push, push_last;

  logic [PAYLOAD_BITS:0]   mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    empty, full, pop, wr_en;

  // The staged byte leaves whenever the frame moves on: next byte, BREAK, disable or idle expiry.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (state == FRAME) begin
      if (!enable) begin
        push      = 1'b1;
        push_last = 1'b1;
      end else if (rx_valid) begin
        push      = 1'b1;
        push_last = rx_break;
      end else if (timer == TMO_LAST) begin
        push      = 1'b1;
        push_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= OFF;
      uart_rx_en <= 1'b0;
      stage      <= '0;
      timer      <= '0;
      break_det  <= 1'b0;
    end else begin
      break_det <= 1'b0;
      case (state)
        OFF: if (enable) begin
          state      <= ARMED;
          uart_rx_en <= 1'b1;
        end
        ARMED: if (!enable) begin
          state      <= OFF;
          uart_rx_en <= 1'b0;
        end else if (rx_valid) begin
          if (rx_break) break_det <= 1'b1;
          else begin
            stage <= rx_data;
            timer <= '0;
            state <= FRAME;
          end
        end
        FRAME: if (!enable) begin
          state      <= OFF;
          uart_rx_en <= 1'b0;
        end else if (rx_valid) begin
          if (rx_break) begin
            break_det <= 1'b1;
            state     <= ARMED;
          end else begin
            stage <= rx_data;
            timer <= '0;
          end
        end else if (timer == TMO_LAST) begin
          state <= ARMED;
        end else begin
          timer <= timer + 1'b1;
        end
        default: begin
          state      <= OFF;
          uart_rx_en <= 1'b0;
        end
      endcase
    end
  end

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop        = !empty && m_ready;
  assign wr_en      = push && (!full || pop);
  assign m_valid    = !empty;
  assign m_data     = empty ? '0 : mem[rd_ptr[AW-1:0]][PAYLOAD_BITS-1:0];
  assign m_last     = !empty && mem[rd_ptr[AW-1:0]][PAYLOAD_BITS];
  assign fifo_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_last, stage};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_ovf)       overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a scoreboard of expected {last,data} pops.
module tb_uart_rx_frame_ctrl;
  localparam int T = (1000 / 100) * 3;

  logic       clk = 1'b0;
  logic       reset, enable, rx_valid, rx_break, m_ready, clear_ovf;
  logic [7:0] rx_data;
  logic       uart_rx_en, m_last, m_valid, overflow, break_det;
  logic [7:0] m_data;
  logic [3:0] fifo_level;

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;
  int base;
  logic [8:0] sb[$];

  uart_rx_frame_ctrl #(
    .PAYLOAD_BITS(8), .CLK_HZ(1000), .BIT_RATE(100), .IDLE_BITS(3), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_valid(rx_valid),
    .rx_break(rx_break), .rx_data(rx_data), .uart_rx_en(uart_rx_en),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_level(fifo_level), .overflow(overflow), .clear_ovf(clear_ovf),
    .break_det(break_det)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic b);
    rx_data  = d;
    rx_break = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 60 && fifo_level != 0; i++) tick();
    chk(tag, fifo_level, 0);
  endtask

  // Pops are compared against the scoreboard in the order the stimulus queued them.
  logic [8:0] e;
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", {m_last, m_data}, 9'h1ff);
      else begin
        e = sb.pop_front();
        chk("pop_data", m_data, e[7:0]);
        chk("pop_last", m_last, e[8]);
      end
      pop_cnt++;
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_break = 1'b0;
    rx_data = '0; m_ready = 1'b0; clear_ovf = 1'b0;
    repeat (3) tick();
    chk("rst_rx_en", uart_rx_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf_brk_data", {overflow, break_det, m_last, m_data}, 0);
    reset = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("en_rx_en", uart_rx_en, 1);
    chk("en_m_valid", m_valid, 0);

    // Three bytes one bit period apart, closed by idle timeout.
    sb.push_back({1'b0, 8'h41}); sb.push_back({1'b0, 8'h42}); sb.push_back({1'b1, 8'h43});
    send(8'h41, 1'b0); repeat (9) tick();
    send(8'h42, 1'b0); repeat (9) tick();
    send(8'h43, 1'b0);
    chk("abc_level2", fifo_level, 2);
    repeat (T - 1) tick();
    chk("abc_before_tmo", fifo_level, 2);
    tick();
    chk("abc_after_tmo", fifo_level, 3);
    m_ready = 1'b1;
    wait_empty("abc_drain");

    // BREAK while armed: pulse only, nothing queued.
    send(8'h00, 1'b1);
    chk("brk_armed_pulse", break_det, 1);
    tick();
    chk("brk_armed_clear", break_det, 0);
    chk("brk_armed_level", fifo_level, 0);

    // BREAK closes a frame.
    sb.push_back({1'b1, 8'h55});
    send(8'h55, 1'b0); repeat (3) tick();
    send(8'h00, 1'b1);
    chk("brk_pulse", break_det, 1);
    tick();
    chk("brk_single", break_det, 0);
    wait_empty("brk_drain");
    chk("brk_sb_empty", sb.size(), 0);

    // Overflow: ten bytes into a stalled 8-entry FIFO.
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) sb.push_back({1'b0, 8'(i)});
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), 1'b0);
      tick();
    end
    repeat (T + 2) tick();
    chk("ovf_level", fifo_level, 8);
    chk("ovf_set", overflow, 1);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("ovf_clear", overflow, 0);
    base = pop_cnt;
    m_ready = 1'b1;
    wait_empty("ovf_drain");
    chk("ovf_pops", pop_cnt - base, 8);

    // Push into a full FIFO while the head is popped in the same cycle.
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) sb.push_back({1'b0, 8'h10 + 8'(i)});
    sb.push_back({1'b1, 8'h19});
    for (int i = 0; i < 9; i++) begin
      send(8'h10 + 8'(i), 1'b0);
      if (i < 8) tick();
    end
    chk("full_level", fifo_level, 8);
    m_ready = 1'b1;
    send(8'h19, 1'b0);
    chk("pushpop_level", fifo_level, 8);
    chk("pushpop_ovf", overflow, 0);
    repeat (T + 5) tick();
    wait_empty("pushpop_drain");
    chk("pushpop_ovf_end", overflow, 0);
    chk("pushpop_sb_empty", sb.size(), 0);

    // Disable mid-frame closes it; later bytes are ignored.
    sb.push_back({1'b1, 8'h7e});
    send(8'h7e, 1'b0); repeat (2) tick();
    enable = 1'b0;
    tick();
    chk("dis_rx_en", uart_rx_en, 0);
    wait_empty("dis_drain");
    base = pop_cnt;
    send(8'h99, 1'b0);
    repeat (T + 5) tick();
    chk("off_ignored_level", fifo_level, 0);
    chk("off_ignored_pops", pop_cnt - base, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
